// File: rtl/ro_pair_enable_seq.sv
// Ring-oscillator pair enable sequencer: decodes a challenge pair, then runs settle / gate / drain.
// Optional abort input is compiled in when RO_ABORT_EN is defined.
module ro_pair_enable_seq #(
   parameter int unsigned SETTLE_CYCLES = 16,
   parameter int unsigned WINDOW_CYCLES = 1024,
   parameter int unsigned DRAIN_CYCLES  = 2,
   parameter int unsigned CNT_W         = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
`ifdef RO_ABORT_EN
   input  logic        abort,
`endif
   input  logic [3:0]  idx_a,
   input  logic [3:0]  idx_b,
   output logic [15:0] ro_en,
   output logic [3:0]  sel_a,
   output logic [3:0]  sel_b,
   output logic        gate,
   output logic        busy,
   output logic        done,
   output logic        err
);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_SETTLE  = 3'd1,
      ST_MEASURE = 3'd2,
      ST_DRAIN   = 3'd3,
      ST_FINISH  = 3'd4
   } state_t;

   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] WINDOW_LAST = CNT_W'(WINDOW_CYCLES - 1);
   localparam logic [CNT_W-1:0] DRAIN_LAST  = CNT_W'(DRAIN_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

   function automatic logic [15:0] idx_to_mask(input logic [3:0] idx);
      idx_to_mask = 16'h0001 << idx;
   endfunction

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [3:0]        sel_a_q, sel_a_d;
   logic [3:0]        sel_b_q, sel_b_d;
   logic              err_flag_q, err_flag_d;
   logic [15:0]       ro_en_q, ro_en_d;
   logic              gate_q, gate_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              err_q, err_d;
   logic              abort_s;

`ifdef RO_ABORT_EN
   assign abort_s = abort;
`else
   assign abort_s = 1'b0;
`endif

   // State, counter and latched challenge registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         sel_a_q    <= 4'd0;
         sel_b_q    <= 4'd0;
         err_flag_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         sel_a_q    <= sel_a_d;
         sel_b_q    <= sel_b_d;
         err_flag_q <= err_flag_d;
      end
   end

   // Next-state logic; the counter restarts at zero on every state entry
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q + CNT_ONE;
      sel_a_d    = sel_a_q;
      sel_b_d    = sel_b_q;
      err_flag_d = err_flag_q;
      case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            if (start) begin
               sel_a_d = idx_a;
               sel_b_d = idx_b;
               if (idx_a == idx_b) begin
                  state_d    = ST_FINISH;
                  err_flag_d = 1'b1;
               end else begin
                  state_d    = ST_SETTLE;
                  err_flag_d = 1'b0;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_SETTLE: begin
            if (abort_s) begin
               state_d    = ST_FINISH;
               err_flag_d = 1'b1;
               cnt_d      = '0;
            end else if (cnt_q == SETTLE_LAST) begin
               state_d = ST_MEASURE;
               cnt_d   = '0;
            end else begin
               state_d = ST_SETTLE;
            end
         end
         ST_MEASURE: begin
            if (abort_s) begin
               state_d    = ST_FINISH;
               err_flag_d = 1'b1;
               cnt_d      = '0;
            end else if (cnt_q == WINDOW_LAST) begin
               state_d = ST_DRAIN;
               cnt_d   = '0;
            end else begin
               state_d = ST_MEASURE;
            end
         end
         ST_DRAIN: begin
            if (abort_s) begin
               state_d    = ST_FINISH;
               err_flag_d = 1'b1;
               cnt_d      = '0;
            end else if (cnt_q == DRAIN_LAST) begin
               state_d = ST_FINISH;
               cnt_d   = '0;
            end else begin
               state_d = ST_DRAIN;
            end
         end
         ST_FINISH: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
         default: begin
            state_d    = ST_IDLE;
            cnt_d      = '0;
            err_flag_d = 1'b0;
         end
      endcase
   end

   // Output decode from the next state so registered outputs line up with state_q
   always_comb begin
      ro_en_d = 16'h0000;
      gate_d  = 1'b0;
      busy_d  = (state_d != ST_IDLE);
      done_d  = (state_d == ST_FINISH);
      err_d   = (state_d == ST_FINISH) & err_flag_d;
      case (state_d)
         ST_SETTLE: begin
            ro_en_d = idx_to_mask(sel_a_d) | idx_to_mask(sel_b_d);
         end
         ST_MEASURE: begin
            ro_en_d = idx_to_mask(sel_a_d) | idx_to_mask(sel_b_d);
            gate_d  = 1'b1;
         end
         default: begin
            ro_en_d = 16'h0000;
            gate_d  = 1'b0;
         end
      endcase
   end

   // Output registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ro_en_q <= 16'h0000;
         gate_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         ro_en_q <= ro_en_d;
         gate_q  <= gate_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   assign ro_en = ro_en_q;
   assign sel_a = sel_a_q;
   assign sel_b = sel_b_q;
   assign gate  = gate_q;
   assign busy  = busy_q;
   assign done  = done_q;
   assign err   = err_q;

endmodule

// File: tb/tb_ro_pair_enable_seq.sv
// Directed bench: a per-cycle vector table on a short-timing instance, plus
// hand-written long sequences on a default-timing instance.
module tb_ro_pair_enable_seq;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // default-parameter instance
   logic        d_rst_n, d_start;
   logic [3:0]  d_idx_a, d_idx_b, d_sel_a, d_sel_b;
   logic [15:0] d_ro_en;
   logic        d_gate, d_busy, d_done, d_err;
   // short-timing instance (1/1/1)
   logic        s_rst_n, s_start;
   logic [3:0]  s_idx_a, s_idx_b, s_sel_a, s_sel_b;
   logic [15:0] s_ro_en;
   logic        s_gate, s_busy, s_done, s_err;
`ifdef RO_ABORT_EN
   logic        d_abort, s_abort;
`endif

   ro_pair_enable_seq u_def (
      .clk(clk), .rst_n(d_rst_n), .start(d_start),
`ifdef RO_ABORT_EN
      .abort(d_abort),
`endif
      .idx_a(d_idx_a), .idx_b(d_idx_b), .ro_en(d_ro_en), .sel_a(d_sel_a), .sel_b(d_sel_b),
      .gate(d_gate), .busy(d_busy), .done(d_done), .err(d_err)
   );

   ro_pair_enable_seq #(.SETTLE_CYCLES(1), .WINDOW_CYCLES(1), .DRAIN_CYCLES(1), .CNT_W(16)) u_sml (
      .clk(clk), .rst_n(s_rst_n), .start(s_start),
`ifdef RO_ABORT_EN
      .abort(s_abort),
`endif
      .idx_a(s_idx_a), .idx_b(s_idx_b), .ro_en(s_ro_en), .sel_a(s_sel_a), .sel_b(s_sel_b),
      .gate(s_gate), .busy(s_busy), .done(s_done), .err(s_err)
   );

   typedef struct {
      logic        rst_n;
      logic        start;
      logic [3:0]  a;
      logic [3:0]  b;
      logic [27:0] exp;   // {ro_en, sel_a, sel_b, gate, busy, done, err}
   } vec_t;

   vec_t vecs[21];

   function automatic vec_t v(input logic rst_n, input logic start, input logic [3:0] a,
                              input logic [3:0] b, input logic [15:0] ro, input logic [3:0] sa,
                              input logic [3:0] sb, input logic g, input logic bu,
                              input logic dn, input logic er);
      vec_t r;
      r.rst_n = rst_n;
      r.start = start;
      r.a     = a;
      r.b     = b;
      r.exp   = {ro, sa, sb, g, bu, dn, er};
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h", name, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [27:0] d_outs();
      return {d_ro_en, d_sel_a, d_sel_b, d_gate, d_busy, d_done, d_err};
   endfunction

   int k, first_k, last_k, gate_cnt, done_k, ro_bad, busy_bad, done_cnt;
   logic err_seen;

   initial begin
      d_rst_n = 1'b0; d_start = 1'b0; d_idx_a = 4'd0; d_idx_b = 4'd0;
      s_rst_n = 1'b0; s_start = 1'b0; s_idx_a = 4'd0; s_idx_b = 4'd0;
`ifdef RO_ABORT_EN
      d_abort = 1'b0; s_abort = 1'b0;
`endif

      //        rst start a   b    ro_en     sa  sb  g  bu dn er
      vecs[0]  = v(0, 0,  0,  0,  16'h0000,  0,  0, 0, 0, 0, 0);
      vecs[1]  = v(1, 1,  0, 15,  16'h8001,  0, 15, 0, 1, 0, 0);
      vecs[2]  = v(1, 0,  0,  0,  16'h8001,  0, 15, 1, 1, 0, 0);
      vecs[3]  = v(1, 0,  0,  0,  16'h0000,  0, 15, 0, 1, 0, 0);
      vecs[4]  = v(1, 0,  0,  0,  16'h0000,  0, 15, 0, 1, 1, 0);
      vecs[5]  = v(1, 0,  0,  0,  16'h0000,  0, 15, 0, 0, 0, 0);
      vecs[6]  = v(1, 1,  5,  5,  16'h0000,  5,  5, 0, 1, 1, 1);
      vecs[7]  = v(1, 1,  2,  9,  16'h0000,  5,  5, 0, 0, 0, 0);
      vecs[8]  = v(1, 1,  2,  9,  16'h0204,  2,  9, 0, 1, 0, 0);
      vecs[9]  = v(1, 1,  1,  0,  16'h0204,  2,  9, 1, 1, 0, 0);
      vecs[10] = v(0, 0,  0,  0,  16'h0000,  0,  0, 0, 0, 0, 0);
      vecs[11] = v(1, 0,  0,  0,  16'h0000,  0,  0, 0, 0, 0, 0);
      vecs[12] = v(1, 1, 15, 14,  16'hC000, 15, 14, 0, 1, 0, 0);
      vecs[13] = v(1, 0,  0,  0,  16'hC000, 15, 14, 1, 1, 0, 0);
      vecs[14] = v(1, 0,  0,  0,  16'h0000, 15, 14, 0, 1, 0, 0);
      vecs[15] = v(1, 1,  3,  4,  16'h0000, 15, 14, 0, 1, 1, 0);
      vecs[16] = v(1, 1,  3,  4,  16'h0000, 15, 14, 0, 0, 0, 0);
      vecs[17] = v(1, 1,  3,  4,  16'h0018,  3,  4, 0, 1, 0, 0);
      vecs[18] = v(1, 0,  0,  0,  16'h0018,  3,  4, 1, 1, 0, 0);
      vecs[19] = v(1, 0,  0,  0,  16'h0000,  3,  4, 0, 1, 0, 0);
      vecs[20] = v(1, 0,  0,  0,  16'h0000,  3,  4, 0, 1, 1, 0);

      #1;
      for (int i = 0; i < 21; i++) begin
         s_rst_n = vecs[i].rst_n;
         s_start = vecs[i].start;
         s_idx_a = vecs[i].a;
         s_idx_b = vecs[i].b;
         step();
         check($sformatf("vec%0d", i),
               {4'd0, s_ro_en, s_sel_a, s_sel_b, s_gate, s_busy, s_done, s_err},
               {4'd0, vecs[i].exp});
      end
      s_start = 1'b0;

      // default timing: reset state, then pair 3/12 with ignored starts mid-window
      step();
      d_rst_n = 1'b1;
      check("def_reset", {4'd0, d_outs()}, 32'd0);
      d_idx_a = 4'd3; d_idx_b = 4'd12; d_start = 1'b1;
      step();
      d_start = 1'b0;
      check("def_t0p1", {4'd0, d_outs()}, {4'd0, 16'h1008, 4'd3, 4'd12, 1'b0, 1'b1, 1'b0, 1'b0});
      k = 1; first_k = -1; last_k = -1; gate_cnt = 0; done_k = -1;
      ro_bad = 0; busy_bad = 0; err_seen = 1'b0;
      while (k < 1200 && done_k < 0) begin
         if (d_gate) begin
            if (first_k < 0) first_k = k;
            gate_cnt++;
            last_k = k;
         end
         if (k <= 1040 && d_ro_en !== 16'h1008) ro_bad++;
         if (k > 1040 && d_ro_en !== 16'h0000) ro_bad++;
         if (!d_busy) busy_bad++;
         if (d_done) begin
            done_k = k;
            err_seen = d_err;
         end else begin
            d_start = (k >= 100 && k < 105);
            d_idx_a = 4'd0;
            d_idx_b = 4'd1;
            step();
            k++;
         end
      end
      d_start = 1'b0;
      check("gate_first", first_k, 32'd17);
      check("gate_len", gate_cnt, 32'd1024);
      check("gate_last", last_k, 32'd1040);
      check("done_cycle", done_k, 32'd1043);
      check("done_err", {31'd0, err_seen}, 32'd0);
      check("ro_en_hold", ro_bad, 32'd0);
      check("busy_hold", busy_bad, 32'd0);
      check("sel_kept", {24'd0, d_sel_a, d_sel_b}, {24'd0, 4'd3, 4'd12});

      // rejected pair right after returning to IDLE
      step();
      check("idle_after_done", {4'd0, d_outs()}, {4'd0, 16'h0000, 4'd3, 4'd12, 4'b0000});
      d_idx_a = 4'd7; d_idx_b = 4'd7; d_start = 1'b1;
      step();
      d_start = 1'b0;
      check("reject_done", {4'd0, d_outs()}, {4'd0, 16'h0000, 4'd7, 4'd7, 1'b0, 1'b1, 1'b1, 1'b1});
      ro_bad = 0;
      for (int i = 0; i < 5; i++) begin
         step();
         if (d_gate || d_ro_en !== 16'h0000 || d_done || d_busy) ro_bad++;
      end
      check("reject_quiet", ro_bad, 32'd0);

      // reset for one cycle mid-window
      d_idx_a = 4'd1; d_idx_b = 4'd2; d_start = 1'b1;
      step();
      d_start = 1'b0;
      for (int i = 0; i < 50; i++) step();
      check("mid_measure_gate", {31'd0, d_gate}, 32'd1);
      d_rst_n = 1'b0;
      step();
      d_rst_n = 1'b1;
      check("mid_reset_outs", {4'd0, d_outs()}, 32'd0);
      done_cnt = 0;
      for (int i = 0; i < 1100; i++) begin
         step();
         if (d_done || d_busy) done_cnt++;
      end
      check("mid_reset_no_done", done_cnt, 32'd0);

`ifdef RO_ABORT_EN
      // abort during the fifth gate cycle
      d_idx_a = 4'd3; d_idx_b = 4'd12; d_start = 1'b1;
      step();
      d_start = 1'b0;
      for (int i = 1; i < 21; i++) step();
      check("abort_pre_gate", {31'd0, d_gate}, 32'd1);
      d_abort = 1'b1;
      step();
      d_abort = 1'b0;
      check("abort_finish", {4'd0, d_outs()}, {4'd0, 16'h0000, 4'd3, 4'd12, 1'b0, 1'b1, 1'b1, 1'b1});
      step();
      check("abort_idle", {4'd0, d_outs()}, {4'd0, 16'h0000, 4'd3, 4'd12, 4'b0000});
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
